// File: rtl/toggle_period_monitor.sv
// toggle_period_monitor: measures rise-to-rise period of sig_in, counts edges and flags a stall.
// Latency: a period sample appears on per_data one cycle after the rise that closes it.
// Backpressure: FWFT sample FIFO; a sample arriving while full with no pop is dropped and overflow sets.

// tpm_fifo: small first-word-fall-through FIFO holding period samples.
// Latency: an entry pushed at clock edge k is visible on head_dat_o in cycle k+1.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module tpm_fifo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_dat_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]  wr_ptr_q;
    logic [PTR_W:0]  rd_ptr_q;
    logic [DW-1:0]   mem_q [DEPTH];
    logic            wr_en;
    logic            rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A pop on an empty FIFO is meaningless; a push into a full FIFO only
    // lands if the head is leaving in the same cycle.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    // Head is forced to zero when nothing is stored so stale data never leaks out.
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer update; reset empties the FIFO and discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage write; contents are only observable through the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat_i;
        end
    end
endmodule

module toggle_period_monitor #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic             per_valid,
    input  logic             per_ready,
    output logic [CNT_W-1:0] per_data,
    output logic             stalled,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic [31:0]      toggle_cnt
);
    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_MEAS  = 2'd2,
        S_STALL = 2'd3
    } state_t;

    state_t            state_q;
    logic              sig_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDLE_W-1:0] idle_q;
    logic              stalled_q;
    logic              ovf_q;
    logic [31:0]       tog_q;

    logic              rise;
    logic              edge_w;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDLE_W-1:0] idle_d;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;

    // Edges are judged against last cycle's sample of sig_in.
    assign rise   = sig_in & ~sig_q;
    assign edge_w = sig_in ^ sig_q;

    // Period counter saturates so a very slow signal reports the maximum instead of wrapping.
    assign cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    assign idle_d = idle_q + IDLE_ONE;

    // Only a rise that closes a full period in MEAS produces a sample.
    assign push = en && (state_q == S_MEAS) && rise;
    assign pop  = per_ready && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    // Delayed copy of sig_in, kept running even while disabled so the first
    // enabled cycle does not see a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_in;
        end
    end

    // Free-running edge counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tog_q <= '0;
        end else if (en && edge_w) begin
            tog_q <= tog_q + 32'd1;
        end
    end

    // Measurement FSM: period counter, idle (stall) counter and registered stall flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idle_q    <= '0;
            stalled_q <= 1'b0;
        end else if (!en) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idle_q    <= '0;
            stalled_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_ARM;
                    cnt_q   <= '0;
                    idle_q  <= '0;
                end
                S_ARM: begin
                    // First rise only establishes the reference point.
                    if (rise) begin
                        state_q <= S_MEAS;
                        cnt_q   <= CNT_ONE;
                        idle_q  <= '0;
                    end else if (edge_w) begin
                        idle_q <= '0;
                    end else if (idle_q == IDLE_LAST) begin
                        state_q   <= S_STALL;
                        stalled_q <= 1'b1;
                        idle_q    <= idle_d;
                    end else begin
                        idle_q <= idle_d;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        cnt_q  <= CNT_ONE;
                        idle_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (edge_w) begin
                            idle_q <= '0;
                        end else if (idle_q == IDLE_LAST) begin
                            state_q   <= S_STALL;
                            stalled_q <= 1'b1;
                            idle_q    <= idle_d;
                        end else begin
                            idle_q <= idle_d;
                        end
                    end
                end
                S_STALL: begin
                    // The period spanning the stall is meaningless, so the
                    // recovering rise restarts measurement without a sample.
                    if (rise) begin
                        state_q   <= S_MEAS;
                        cnt_q     <= CNT_ONE;
                        idle_q    <= '0;
                        stalled_q <= 1'b0;
                    end else if (edge_w) begin
                        idle_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear leaves it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    tpm_fifo #(
        .DW    (CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (cnt_q),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_dat_o (per_data)
    );

    assign per_valid  = !fifo_empty;
    assign stalled    = stalled_q;
    assign overflow   = ovf_q;
    assign toggle_cnt = tog_q;
endmodule

// File: tb/tb_toggle_period_monitor.sv
// tb_toggle_period_monitor: randomized and directed stimulus against a timestamp-based reference model.
// Latency: expected samples are queued at the predicted push and compared when the DUT offers them.
// Backpressure: per_ready is driven by the bench; the model applies the same FIFO capacity rules.
module tb_toggle_period_monitor;
    localparam int     CNT_W   = 16;
    localparam int     TIMEOUT = 1000;
    localparam int     DEPTH   = 4;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, en, sig_in, per_ready, clr_ovf;
    logic             per_valid, stalled, overflow;
    logic [CNT_W-1:0] per_data;
    logic [31:0]      toggle_cnt;

    toggle_period_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .per_valid(per_valid), .per_ready(per_ready), .per_data(per_data),
        .stalled(stalled), .overflow(overflow), .clr_ovf(clr_ovf), .toggle_cnt(toggle_cnt)
    );

    // Narrow-counter instance used to reach saturation within a short run.
    logic        rst2, en2, sig2, per_valid2, stalled2, overflow2;
    logic [7:0]  per_data2;
    logic [31:0] toggle_cnt2;

    toggle_period_monitor #(.CNT_W(8), .TIMEOUT(600), .FIFO_DEPTH(2)) u_sat (
        .clk(clk), .rst(rst2), .en(en2), .sig_in(sig2),
        .per_valid(per_valid2), .per_ready(1'b1), .per_data(per_data2),
        .stalled(stalled2), .overflow(overflow2), .clr_ovf(1'b0), .toggle_cnt(toggle_cnt2)
    );

    int errors = 0;
    int checks = 0;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: timestamps of the last rise and last edge, plus the expected FIFO contents.
    int          sb[$];
    bit          m_prev = 1'b0;
    bit          m_active = 1'b0;
    bit          m_stall = 1'b0;
    bit          m_ovf = 1'b0;
    longint      m_cyc = 0;
    longint      m_ref = -1;
    longint      m_last_edge = 0;
    logic [31:0] m_tog = '0;
    bit          mon_on = 1'b0;
    bit          sat_done = 1'b0;
    int          n_pops = 0;
    longint      exp_v;

    task automatic model_step();
        bit     e, r, dropped;
        longint p;
        dropped = 1'b0;
        m_cyc++;
        e = (sig_in != m_prev);
        r = sig_in && !m_prev;
        m_prev = sig_in;
        if (en && e) m_tog++;
        if (!en) begin
            m_active = 1'b0;
            m_stall  = 1'b0;
            m_ref    = -1;
        end else if (!m_active) begin
            m_active    = 1'b1;
            m_last_edge = m_cyc;
            m_ref       = -1;
        end else if (m_stall) begin
            if (e) m_last_edge = m_cyc;
            if (r) begin
                m_stall = 1'b0;
                m_ref   = m_cyc;
            end
        end else if (e) begin
            m_last_edge = m_cyc;
            if (r) begin
                if (m_ref >= 0) begin
                    p = m_cyc - m_ref;
                    if (p > CNT_MAX) p = CNT_MAX;
                    if (sb.size() < DEPTH) sb.push_back(int'(p));
                    else dropped = 1'b1;
                end
                m_ref = m_cyc;
            end
        end else if (m_cyc - m_last_edge == TIMEOUT) begin
            m_stall = 1'b1;
            m_ref   = -1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb.delete();
            m_prev = 1'b0; m_active = 1'b0; m_stall = 1'b0; m_ovf = 1'b0;
            m_ref = -1; m_last_edge = 0; m_tog = '0;
        end else begin
            model_step();
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each accepted sample.
    always @(negedge clk) begin
        if (mon_on) begin
            check("per_valid", longint'(per_valid), longint'(sb.size() != 0));
            check("stalled", longint'(stalled), longint'(m_stall));
            check("overflow", longint'(overflow), longint'(m_ovf));
            check("toggle_cnt", longint'(toggle_cnt), longint'(m_tog));
            if (per_valid && sb.size() != 0) check("per_data_head", longint'(per_data), longint'(sb[0]));
            if (!per_valid) check("per_data_empty", longint'(per_data), 0);
            if (per_valid && per_ready) begin
                if (sb.size() != 0) exp_v = longint'(sb.pop_front());
                else exp_v = -1;
                check("per_data_pop", longint'(per_data), exp_v);
                n_pops++;
            end
        end
    end

    task automatic drive(input bit e, input bit s, input bit r, input bit c);
        @(posedge clk);
        #2;
        en = e; sig_in = s; per_ready = r; clr_ovf = c;
    endtask

    int ph = 0;
    task automatic sq(input bit r, input bit c);
        drive(1'b1, (ph % 10) < 5, r, c);
        ph++;
    endtask

    task automatic sat_test();
        @(posedge clk); #2 en2 = 1'b1;
        repeat (5) @(posedge clk);
        #2 sig2 = 1'b1;
        repeat (150) @(posedge clk);
        #2 sig2 = 1'b0;
        repeat (149) @(posedge clk);
        #2 sig2 = 1'b1;
        @(negedge clk);
        check("sat_valid_before", longint'(per_valid2), 0);
        @(negedge clk);
        check("sat_valid", longint'(per_valid2), 1);
        check("sat_data_ff", longint'(per_data2), 255);
        repeat (100) @(posedge clk);
        #2 sig2 = 1'b0;
        repeat (99) @(posedge clk);
        #2 sig2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("sat_valid2", longint'(per_valid2), 1);
        check("sat_data_200", longint'(per_data2), 200);
        check("sat_toggles", longint'(toggle_cnt2), 5);
        check("sat_stalled", longint'(stalled2), 0);
        check("sat_overflow", longint'(overflow2), 0);
        sat_done = 1'b1;
    endtask

    bit s;
    initial begin
        rst = 1'b1; en = 1'b0; sig_in = 1'b0; per_ready = 1'b0; clr_ovf = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; sig2 = 1'b0;
        @(posedge clk); #1 mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0; rst2 = 1'b0;
        fork sat_test(); join_none

        // Toggle every cycle: periods of 2, drained immediately.
        s = 1'b0;
        for (int i = 0; i < 40; i++) begin s = ~s; drive(1'b1, s, 1'b1, 1'b0); end

        // 5 high / 5 low with the consumer stalled: four 10s kept, later ones dropped.
        for (int i = 0; i < 72; i++) drive(1'b1, (i % 10) < 5, i < 12, 1'b0);
        repeat (12) drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);

        // Random fast activity with occasional disable and overflow clears.
        s = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) s = ~s;
            drive($urandom_range(0, 150) != 0, s, $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0);
        end
        // Random slow activity.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) s = ~s;
            drive(1'b1, s, $urandom_range(0, 3) != 0, 1'b0);
        end

        // Lock, freeze past the timeout, recover, then one 37-cycle period.
        for (int i = 0; i < 30; i++) drive(1'b1, (i % 6) < 3, 1'b1, 1'b0);
        repeat (1100) drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (20) drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (17) drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (11) drive(1'b1, 1'b1, 1'b1, 1'b0);

        // Fill, clear overflow, push+pop while full, then drop coinciding with clear.
        ph = 0;
        for (int i = 0; i < 60; i++) sq(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) sq(1'b0, (ph % 10) == 3);
        for (int i = 0; i < 40; i++) sq((ph % 10) == 0, 1'b0);
        for (int i = 0; i < 10; i++) sq(1'b0, (ph % 10) == 0);
        repeat (10) drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Queue three samples, then reset mid-measurement with en held high.
        ph = 0;
        for (int i = 0; i < 45; i++) sq(1'b0, 1'b0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 40; i++) sq(1'b1, 1'b0);

        // Random tail, then disable.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) s = ~s;
            drive(1'b1, s, $urandom_range(0, 1) == 1, $urandom_range(0, 20) == 0);
        end
        repeat (5) drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        check("sat_done", longint'(sat_done), 1);
        check("pops_seen", longint'(n_pops >= 30), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/toggle_period_monitor.md
Name: toggle_period_monitor

Overview:
Downstream consumer of the free-running toggle register inside sub_module. The XMR-elimination flow exports that register as a plain port, and this block receives it as sig_in. It measures the rising-edge-to-rising-edge period in clk cycles, counts all toggles, and flags a stall when the signal stops moving. Period samples leave through a valid/ready FIFO to a status or CSR reader.

Parameters:
CNT_W, 16, width of period counter and per_data
TIMEOUT, 1000, cycles without any sig_in edge before stall is declared (>=2)
FIFO_DEPTH, 4, period-sample FIFO entries (power of 2, >=2)

Ports:
clk  in  1  single clock, rising-edge
rst  in  1  asynchronous reset, active-high
en  in  1  monitor enable
sig_in  in  1  monitored toggle signal, synchronous to clk
per_valid  out  1  FIFO non-empty
per_ready  in  1  consumer accepts head entry
per_data  out  CNT_W  head period sample, in clk cycles
stalled  out  1  no edge for TIMEOUT cycles
overflow  out  1  sticky: a sample was dropped
clr_ovf  in  1  clears overflow
toggle_cnt  out  32  total edges seen while en=1

Behaviour:
- Reset (async, rst=1): state IDLE, sig_d=0, per_valid=0, per_data=0, stalled=0, overflow=0, toggle_cnt=0, FIFO empty, period and idle counters 0.
- Edge detection is combinational on the sampled value:
  - rise = sig_in & ~sig_d
  - edge = sig_in ^ sig_d
  - sig_d <= sig_in every cycle, regardless of en.
- toggle_cnt increments on every clock with en=1 and edge=1. Wraps at 2^32.
- FSM states: IDLE, ARM, MEAS, STALL.
  - IDLE: counters held at 0. en=1 -> ARM next cycle.
  - ARM: idle counter increments each cycle and clears on edge. rise -> MEAS with period cnt=1, no push. Idle counter reaching TIMEOUT -> STALL.
  - MEAS: period cnt increments each cycle, saturating at 2^CNT_W-1. On rise, push the current cnt value into the FIFO and reload cnt=1. Idle counter behaves as in ARM; reaching TIMEOUT -> STALL.
  - STALL: stalled=1, registered on entry. On rise -> MEAS, cnt=1, stalled=0 next cycle, no push (the period spanning the stall is discarded). A falling edge only clears the idle counter; the state stays STALL.
  - en=0 in any state -> IDLE next cycle. stalled clears, counters clear, FIFO contents and overflow are retained.
- Period definition: clock count between successive rise detections. Example: sig_in toggling every cycle gives 2; rise every 10 cycles gives 10.
- FIFO (first-word fall-through):
  - per_valid = !empty; per_data = head entry, 0 when empty.
  - A push at clock edge k makes the entry visible in cycle k+1 (1-cycle latency).
  - Pop when per_valid & per_ready.
  - Push while full with no simultaneous pop: sample dropped, overflow <= 1.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: the push is stored, the pop is ignored (per_valid was 0).
  - Pointers wrap modulo FIFO_DEPTH, with an extra bit to tell full from empty.
- overflow clears on clr_ovf=1. A set event in the same cycle wins over the clear.
- per_ready is ignored when per_valid=0.
- Asserting rst mid-operation immediately returns everything to the reset values above; in-flight samples are lost.

Test Plan:
- Reset then en=1, sig_in toggling every cycle, per_ready=1 -> first sample after second rise, per_data=2 each time, toggle_cnt increments by 1 per cycle, stalled=0.
- sig_in high 5 / low 5 cycles, per_ready=0 for 60 cycles -> 4 samples of 10 retained, 5th and later dropped, overflow=1; then per_ready=1 -> exactly four pops of 10. clr_ovf -> overflow=0.
- sig_in frozen after lock, TIMEOUT=1000 -> stalled rises 1000 cycles after the last edge. Next rise clears stalled with no sample pushed; the following rise pushes the correct period.
- Period longer than 65535 with TIMEOUT raised above it -> per_data=16'hFFFF (saturated).
- Full FIFO with simultaneous push and pop -> occupancy stays 4, order preserved, overflow stays 0. clr_ovf and a drop in the same cycle -> overflow=1.
- rst pulsed mid-measurement with 3 entries queued -> per_valid=0, toggle_cnt=0, state IDLE. With en still 1, ARM on the next cycle and no sample until two rises have occurred.
